// File: rtl/spike_encoder_pkg.sv
// spike_encoder_pkg: shared types and constants for the spike encoder.
//   state_t   : encoder FSM states (IDLE, ENCODE, DONE)
//   LFSR_W    : width of each per-input LFSR
//   LFSR_MASK : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   seed_for  : per-input seed = base rotated left by the input index
package spike_encoder_pkg;

    typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    // Distinct rotations keep the per-input streams decorrelated while
    // staying nonzero whenever the base seed is nonzero.
    function automatic logic [LFSR_W-1:0] seed_for(input int idx,
                                                   input logic [LFSR_W-1:0] base);
        int r;
        r = idx % LFSR_W;
        if (r == 0) return base;
        return (base << r) | (base >> (LFSR_W - r));
    endfunction

endpackage

// File: rtl/spike_lfsr.sv
// spike_lfsr: one 16-bit Galois LFSR used as a per-input random source.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, loads seed
//   advance  : step the LFSR one position; otherwise it holds
//   seed     : reset value (must be nonzero)
//   rand_val : low OUT_W bits of the current LFSR state
module spike_lfsr
    import spike_encoder_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic [OUT_W-1:0]  rand_val
);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= seed;
        else if (advance)
            lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
    end

    assign rand_val = lfsr[OUT_W-1:0];

endmodule

// File: rtl/spike_encoder.sv
// spike_encoder: rate-coding front end for the spiking network.
// Accepts one frame of N_INPUTS pixels, then presents N_CYCLES spike vectors,
// advancing on each accepted network sample strobe, and pulses frame_done.
//   clk, rst     : clock and synchronous active-high reset
//   pix_valid    : frame on pix_data is valid
//   pix_ready    : encoder idle and able to take a frame
//   pix_data     : pixel i at bits [i*PIXEL_W +: PIXEL_W]
//   sample       : network strobe consuming the current in_spikes
//   sample_ready : in_spikes holds a valid vector
//   in_spikes    : spike vector, zero whenever sample_ready is low
//   frame_done   : one-cycle pulse after the last sample of a frame
// Build option: SPIKE_ENCODER_DETERMINISTIC_EN replaces the LFSRs with
// per-input phase accumulators whose carry-out is the spike.
module spike_encoder
    import spike_encoder_pkg::*;
#(
    parameter int                N_INPUTS  = 4,
    parameter int                PIXEL_W   = 8,
    parameter int                N_CYCLES  = 10,
    parameter int                CNT_W     = 5,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [N_INPUTS*PIXEL_W-1:0]   pix_data,
    input  logic                          sample,
    output logic                          sample_ready,
    output logic [N_INPUTS-1:0]           in_spikes,
    output logic                          frame_done
);

    state_t                           state, state_nxt;
    logic [N_INPUTS-1:0][PIXEL_W-1:0] pix_q;
    logic [CNT_W-1:0]                 cnt;
    logic                             vec_vld;
    logic [N_INPUTS-1:0]              spk;
    logic                             take, fire, last;

    assign take = (state == IDLE) && pix_valid;
    assign fire = (state == ENCODE) && sample && vec_vld;
    assign last = fire && (cnt == CNT_W'(N_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                pix_ready = 1'b1;
                if (pix_valid) state_nxt = ENCODE;
            end
            ENCODE: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // vec_vld stays low through the ENCODE entry cycle so the first vector
    // appears one cycle after the frame is taken, and drops entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            vec_vld <= 1'b0;
            pix_q   <= '0;
        end else begin
            vec_vld <= (state == ENCODE) && (state_nxt == ENCODE);
            if (take) begin
                pix_q <= pix_data;
                cnt   <= '0;
            end else if (fire) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Spike vectors are a function of registered state only (latched pixels
    // plus LFSR/accumulator), so they stay stable between accepted samples.
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_lane
        logic all_ones;
        assign all_ones = &pix_q[i];
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
        logic [PIXEL_W-1:0] acc;
        logic [PIXEL_W:0]   sum;
        assign sum = {1'b0, acc} + {1'b0, pix_q[i]};
        always_ff @(posedge clk) begin
            if (rst || take) acc <= '0;
            else if (fire)   acc <= sum[PIXEL_W-1:0];
        end
        // The presented spike is the carry this sample's addition produces.
        assign spk[i] = all_ones | sum[PIXEL_W];
`else
        localparam logic [LFSR_W-1:0] SEED = seed_for(i, LFSR_SEED);
        logic [PIXEL_W-1:0] rnd;
        spike_lfsr #(.OUT_W(PIXEL_W)) u_lfsr (
            .clk      (clk),
            .rst      (rst),
            .advance  (fire),
            .seed     (SEED),
            .rand_val (rnd)
        );
        assign spk[i] = all_ones | (rnd < pix_q[i]);
`endif
    end

    assign sample_ready = vec_vld;
    assign in_spikes    = vec_vld ? spk : '0;

endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder: directed sequence with random pixels and gaps, checked
// against a behavioural rate-coding model.
module tb_spike_encoder;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NC = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           pix_valid = 1'b0;
    logic           sample = 1'b0;
    logic [N*W-1:0] pix_data = '0;
    logic           pix_ready, sample_ready, frame_done;
    logic [N-1:0]   in_spikes;

    spike_encoder #(
        .N_INPUTS(N), .PIXEL_W(W), .N_CYCLES(NC), .CNT_W(5), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .sample       (sample),
        .sample_ready (sample_ready),
        .in_spikes    (in_spikes),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    // Reference model state
    logic [15:0]  m_lfsr [N];
    logic [W-1:0] m_pix  [N];
    int           m_acc  [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] b, input int i);
        logic [31:0] t;
        t = {b, b} << i;
        return t[31:16];
    endfunction

    task automatic model_reset;
        for (int i = 0; i < N; i++) begin
            m_lfsr[i] = rotl(16'hACE1, i);
            m_acc[i]  = 0;
        end
    endtask

    // Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, plus phase accumulators.
    task automatic model_sample;
        for (int i = 0; i < N; i++) begin
            if (m_lfsr[i][0]) m_lfsr[i] = (m_lfsr[i] >> 1) ^ 16'hB400;
            else              m_lfsr[i] = m_lfsr[i] >> 1;
            m_acc[i] = (m_acc[i] + int'(m_pix[i])) % (1 << W);
        end
    endtask

    function automatic logic [N-1:0] model_spikes();
        logic [N-1:0] s;
        logic [15:0]  r;
        for (int i = 0; i < N; i++) begin
            r = m_lfsr[i];
            if (int'(m_pix[i]) == (1 << W) - 1) s[i] = 1'b1;
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
            else s[i] = (m_acc[i] + int'(m_pix[i])) >= (1 << W);
`else
            else s[i] = int'(r[W-1:0]) < int'(m_pix[i]);
`endif
        end
        return s;
    endfunction

    task automatic start_frame(input logic [N*W-1:0] pix, input bit hold, output int waited);
        pix_valid = 1'b1;
        pix_data  = pix;
        waited    = 0;
        while (pix_ready !== 1'b1 && waited < 8) begin
            tick;
            waited++;
        end
        chk("accept_timeout", 32'(waited < 8), 1);
        tick;
        for (int i = 0; i < N; i++) begin
            m_pix[i] = pix[i*W +: W];
            m_acc[i] = 0;
        end
        chk("entry_sready", sample_ready, 0);
        chk("entry_pready", pix_ready, 0);
        if (hold) pix_data = $urandom;
        else      pix_valid = 1'b0;
        tick;
        chk("first_sready", sample_ready, 1);
    endtask

    task automatic do_sample(input int gap, input bit last, output logic [N-1:0] seen);
        logic [N-1:0] exp;
        exp = model_spikes();
        for (int g = 0; g < gap; g++) begin
            chk("hold_spikes", in_spikes, exp);
            tick;
        end
        chk("spikes", in_spikes, exp);
        chk("sready", sample_ready, 1);
        chk("no_early_done", frame_done, 0);
        seen   = in_spikes;
        sample = 1'b1;
        tick;
        sample = 1'b0;
        model_sample();
        if (last) begin
            chk("done_pulse", frame_done, 1);
            chk("done_sready", sample_ready, 0);
            chk("done_spikes", in_spikes, 0);
            chk("done_pready", pix_ready, 0);
        end
    endtask

    task automatic run_frame(input logic [N*W-1:0] pix, input bit hold, input int gap,
                             output int cnt0, output int cnt1, output int cnt2,
                             output int cnt3, output int waited);
        logic [N-1:0] seen;
        int g;
        cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0;
        start_frame(pix, hold, waited);
        for (int k = 0; k < NC; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            do_sample(g, k == NC - 1, seen);
            cnt0 += int'(seen[0]); cnt1 += int'(seen[1]);
            cnt2 += int'(seen[2]); cnt3 += int'(seen[3]);
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
            if (pix == 32'h00C04080) chk("det_ch0_phase", seen[0], 32'(k % 2 == 1));
`endif
        end
    endtask

    initial begin
        int c0, c1, c2, c3, w, frames;
        logic [N-1:0] seen;
        logic [N*W-1:0] r;
        frames = 0;
        model_reset();

        // Reset held with pix_valid high: nothing may be accepted.
        rst = 1'b1; pix_valid = 1'b1; pix_data = $urandom;
        repeat (3) tick;
        chk("rst_pready", pix_ready, 1);
        chk("rst_sready", sample_ready, 0);
        chk("rst_spikes", in_spikes, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b0; pix_valid = 1'b0;
        tick;
        chk("post_rst_idle", pix_ready, 1);

        // Samples in IDLE must not move the counter (frame length checked later).
        sample = 1'b1;
        repeat (3) tick;
        sample = 1'b0;
        chk("idle_sready", sample_ready, 0);
        chk("idle_spikes", in_spikes, 0);

        // Extremes: FF always fires, 00 never.
        run_frame(32'h00FF00FF, 1'b0, 2, c0, c1, c2, c3, w);
        frames++;
        chk("ext_cnt0", c0, NC); chk("ext_cnt1", c1, 0);
        chk("ext_cnt2", c2, NC); chk("ext_cnt3", c3, 0);

        // Rate frame {80,40,C0,00}.
        run_frame(32'h00C04080, 1'b0, -1, c0, c1, c2, c3, w);
        frames++;
        chk("rate_cnt3", c3, 0);
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
        chk("det_cnt0", c0, 5); chk("det_cnt1", c1, 2); chk("det_cnt2", c2, 7);
`endif

        // Random frames with pix_valid held high and junk data during ENCODE.
        for (int f = 0; f < 2; f++) begin
            run_frame($urandom, 1'b1, -1, c0, c1, c2, c3, w);
            frames++;
        end
        pix_valid = 1'b0;

        // Mid-frame reset after 4 samples, then rerun the same frame.
        r = $urandom;
        start_frame(r, 1'b0, w);
        for (int k = 0; k < 4; k++) do_sample($urandom_range(0, 2), 1'b0, seen);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_reset();
        chk("mid_rst_pready", pix_ready, 1);
        chk("mid_rst_sready", sample_ready, 0);
        chk("mid_rst_spikes", in_spikes, 0);
        chk("mid_rst_done", frame_done, 0);
        tick;
        chk("mid_rst_no_done", frame_done, 0);
        chk("mid_rst_frames", done_cnt, frames);
        run_frame(r, 1'b0, -1, c0, c1, c2, c3, w);
        frames++;

        // Back-to-back frames with pix_valid held high throughout.
        run_frame($urandom, 1'b1, 0, c0, c1, c2, c3, w);
        frames++;
        run_frame($urandom, 1'b1, 1, c0, c1, c2, c3, w);
        frames++;
        chk("b2b_accept_gap", w, 1);
        pix_valid = 1'b0;
        tick;
        chk("final_idle", pix_ready, 1);
        chk("frame_done_count", done_cnt, frames);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
Rate-coding input stage placed directly upstream of the spiking network. Accepts one frame of pixel intensities through a valid/ready handshake. For each network `sample` strobe it produces one spike vector on `in_spikes`, where each input's firing probability is proportional to its pixel intensity. After N_CYCLES samples it releases the frame, pulses `frame_done`, and accepts the next frame.

Parameters:
N_INPUTS, 4, number of spike channels; equals the network in_spikes width.
PIXEL_W, 8, bits per pixel intensity.
N_CYCLES, 10, samples per frame; must match the network's n_cycles.
CNT_W, 5, sample counter width; requires 2^CNT_W > N_CYCLES.
LFSR_SEED, 16'hACE1, base LFSR seed; must be nonzero.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
pix_valid  in  1  frame on pix_data is valid.
pix_ready  out  1  encoder can accept a frame.
pix_data  in  N_INPUTS*PIXEL_W  pixel i occupies bits [i*PIXEL_W +: PIXEL_W].
sample  in  1  one-cycle strobe from the network; consumes the current in_spikes.
sample_ready  out  1  a valid spike vector is presented; drives the network sample_ready.
in_spikes  out  N_INPUTS  spike vector to the network.
frame_done  out  1  one-cycle pulse after the last sample of a frame.

Behaviour:
- Reset values, applied on the first clk edge with rst=1:
  - state=IDLE, pix_ready=1, sample_ready=0, in_spikes=0, frame_done=0, counter=0.
  - Every LFSR is reseeded.
- Reset mid-frame aborts the frame; no frame_done is produced.
- FSM state IDLE:
  - pix_ready=1, sample_ready=0.
  - On pix_valid&&pix_ready: latch pix_data, clear the counter, clear accumulators (if the optional feature is enabled), go to ENCODE.
- FSM state ENCODE:
  - pix_ready=0.
  - The first spike vector is registered on the entry cycle and presented the following cycle, with sample_ready=1 from that cycle on.
  - On sample=1 && sample_ready=1:
    - counter increments.
    - LFSRs advance one step.
    - The next vector is registered and visible the next cycle.
  - When sample arrives with counter==N_CYCLES-1, go to DONE.
- FSM state DONE:
  - Exactly one cycle.
  - frame_done=1, sample_ready=0, in_spikes=0, pix_ready=0.
  - Next state IDLE.
- Spike rule: spike_i = (pix_i == all-ones) || (rand_i < pix_i), unsigned compare.
  - pix_i=0 never fires.
  - pix_i=all-ones always fires.
- Random source:
  - One 16-bit Galois LFSR per input, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Seed_i = LFSR_SEED rotated left by i.
  - rand_i = lfsr_i[PIXEL_W-1:0].
- Ignored inputs:
  - sample while not in ENCODE is ignored; the counter is unchanged.
  - pix_valid outside IDLE is ignored; pix_data is not relatched.
- in_spikes is held stable between accepted samples.
- Throughput: a new frame can be accepted 1 cycle after frame_done.

Optional Feature:
- Macro: SPIKE_ENCODER_DETERMINISTIC_EN.
- When defined, the LFSRs are replaced by per-input PIXEL_W-bit phase accumulators, cleared on frame load.
  - Each accepted sample adds pix_i; spike_i is the carry-out of that addition. pix_i=all-ones still forces a spike.
  - The first presented vector is all-zero.
  - Spike count per frame = floor(N_CYCLES*pix_i/2^PIXEL_W), except for pix=all-ones.
- When undefined, the LFSR behaviour above applies.
- Ports and FSM are identical in both builds.

Decomposition:
- Package spike_encoder_pkg:
  - state enum {IDLE, ENCODE, DONE}.
  - LFSR_W=16 and LFSR_MASK=16'hB400.
  - Function seed_for(idx, base).
- Sub-module spike_lfsr:
  - Ports: clk, rst, advance, seed.
  - Output: rand value.
  - Instantiated N_INPUTS times via generate.
  - Holds its value unless advance=1.

Test Plan:
- Reset: hold rst=1 for 3 cycles with pix_valid=1. Required: pix_ready=1, sample_ready=0, in_spikes=0, frame_done=0, and no frame accepted.
- Extremes: load frame {FF,00,FF,00}, issue 10 sample strobes 3 cycles apart. Required: in_spikes=4'b0101 on every sample; frame_done pulses exactly once, 1 cycle after the 10th strobe; sample_ready=0 in DONE.
- Deterministic rate (SPIKE_ENCODER_DETERMINISTIC_EN): load {80,40,C0,00}. Required spike counts over 10 samples: 5, 2, 7, 0. Channel 0 fires on samples 2,4,6,8,10.
- Handshake protection:
  - pix_valid held high during ENCODE: the frame is not relatched.
  - sample pulses while in IDLE: the counter stays 0.
- Reset mid-frame: after 4 samples assert rst for 1 cycle. Required: IDLE, no frame_done. The next frame yields the same LFSR-mode spike sequence as a fresh post-reset run.
- Back-to-back frames: pix_valid held high continuously. Required: second frame accepted the cycle after frame_done; 20 samples total; two frame_done pulses.
